// File: rtl/clkgate_ctrl_pkg.sv
// Shared types and constants for the clock-gate enable controller.
package clkgate_ctrl_pkg;

    localparam int unsigned CG_CNT_W = 8;

    typedef enum logic [1:0] {
        OFF   = 2'd0,
        WAKE  = 2'd1,
        ON    = 2'd2,
        DRAIN = 2'd3
    } cg_state_t;

endpackage

// File: rtl/cg_dwell_cnt.sv
// Dwell counter shared by the WAKE and DRAIN states: synchronous clear and
// increment, asynchronous reset, and a terminal match against a runtime limit.
import clkgate_ctrl_pkg::*;

module cg_dwell_cnt (
    input  logic                i_clk,
    input  logic                i_rst,
    input  logic                i_clr,
    input  logic                i_inc,
    input  logic [CG_CNT_W-1:0] i_limit,
    output logic                o_match
);

    logic [CG_CNT_W-1:0] r_cnt;

    // Count register; clear has priority over increment.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_cnt <= '0;
        end else if (i_clr) begin
            r_cnt <= '0;
        end else if (i_inc) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    // Terminal match against the currently selected limit.
    always_comb begin
        o_match = (r_cnt == i_limit);
    end

endmodule

// File: rtl/clkgate_enable_ctrl.sv
// Enable controller for a latch-based integrated clock gate. Wakes the gated
// domain on a four-phase REQ/ACK handshake, keeps it running while BUSY, and
// shuts the clock off after an idle dwell. TE forces E high for scan.
import clkgate_ctrl_pkg::*;

module clkgate_enable_ctrl #(
    parameter int unsigned WAKE_CYC = 2,
    parameter int unsigned IDLE_CYC = 16
) (
    input  logic       CK,
    input  logic       RST,
    input  logic       REQ,
    input  logic       BUSY,
    input  logic       TE,
    output logic       ACK,
    output logic       E,
    output logic [1:0] STATE
);

    cg_state_t           r_state;
    cg_state_t           w_state_next;
    logic                r_ack;
    logic                w_cnt_clr;
    logic                w_cnt_inc;
    logic                w_cnt_match;
    logic [CG_CNT_W-1:0] w_cnt_limit;

    // Only WAKE and DRAIN use the counter, so one limit mux covers both.
    always_comb begin
        if (r_state == WAKE) begin
            w_cnt_limit = CG_CNT_W'(WAKE_CYC - 1);
        end else begin
            w_cnt_limit = CG_CNT_W'(IDLE_CYC - 1);
        end
    end

    cg_dwell_cnt u_dwell_cnt (
        .i_clk   (CK),
        .i_rst   (RST),
        .i_clr   (w_cnt_clr),
        .i_inc   (w_cnt_inc),
        .i_limit (w_cnt_limit),
        .o_match (w_cnt_match)
    );

    // Next-state and counter control.
    always_comb begin
        w_state_next = r_state;
        w_cnt_clr    = 1'b0;
        w_cnt_inc    = 1'b0;
        unique case (r_state)
            OFF: begin
                if (REQ) begin
                    w_state_next = WAKE;
                    w_cnt_clr    = 1'b1;
                end
            end
            WAKE: begin
                // REQ is ignored: a wake always runs to completion.
                if (w_cnt_match) begin
                    w_state_next = ON;
                    w_cnt_clr    = 1'b1;
                end else begin
                    w_cnt_inc = 1'b1;
                end
            end
            ON: begin
                if (!REQ && !BUSY) begin
                    w_state_next = DRAIN;
                    w_cnt_clr    = 1'b1;
                end
            end
            DRAIN: begin
                // New activity beats idle expiry; the clock is still running,
                // so no re-wake is needed.
                if (REQ || BUSY) begin
                    w_state_next = ON;
                    w_cnt_clr    = 1'b1;
                end else if (w_cnt_match) begin
                    w_state_next = OFF;
                    w_cnt_clr    = 1'b1;
                end else begin
                    w_cnt_inc = 1'b1;
                end
            end
            default: begin
                w_state_next = OFF;
                w_cnt_clr    = 1'b1;
            end
        endcase
    end

    // State and registered ACK.
    always_ff @(posedge CK or posedge RST) begin
        if (RST) begin
            r_state <= OFF;
            r_ack   <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_ack   <= REQ && (w_state_next == ON);
        end
    end

    // E comes straight from the state flop, so it is stable through the
    // clock-low latch window of the gate cell.
    always_comb begin
        E     = (r_state != OFF) || TE;
        ACK   = r_ack;
        STATE = r_state;
    end

endmodule
